adder_sequencer: RTL and testbench

- Sequences one shared 32-bit ripple carry adder over WORDS consecutive 32-bit limbs to perform multi-precision add or subtract, least-significant word first.
- Holds the inter-word carry in a register between cycles.
- Operands arrive as a valid/ready word stream and results leave as a valid/ready word stream with backpressure.
- Sits between the operand source (register file or DMA) and the result sink in the wide-arithmetic datapath.

---
 rtl/adder_sequencer_pkg.sv | 16 +
 rtl/adder_sequencer_rca.sv | 28 ++
 rtl/adder_sequencer.sv | 121 ++++++++++++
 tb/tb_adder_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/adder_sequencer_pkg.sv
// Shared constants and the FSM state type for the multi-precision adder sequencer.
package adder_sequencer_pkg;

  localparam int LIMB_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    RUN   = S_RUN,
    DRAIN = S_DRAIN
  } state_t;

endpackage

// File: rtl/adder_sequencer_rca.sv
// 32-bit ripple carry adder shared by every limb of the sequenced operation.
module adder_sequencer_rca
  import adder_sequencer_pkg::*;
(
  input  logic [LIMB_W-1:0] i_a,
  input  logic [LIMB_W-1:0] i_b,
  input  logic              i_c,
  output logic [LIMB_W-1:0] o_sum,
  output logic              o_c,
  output logic              o_of
);

  logic [LIMB_W:0] w_carry;

  assign w_carry[0] = i_c;

  generate
    for (genvar gi = 0; gi < LIMB_W; gi++) begin : g_fa
      assign o_sum[gi]      = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi+1]  = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_c  = w_carry[LIMB_W];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign o_of = w_carry[LIMB_W] ^ w_carry[LIMB_W-1];

endmodule

// File: rtl/adder_sequencer.sv
// Multi-precision add/subtract: streams WORDS limbs LSW first through one shared
// ripple carry adder, carrying between limbs, with valid/ready on both sides.
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sub,
  input  logic              cmd_cin,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [LIMB_W-1:0] op_a,
  input  logic [LIMB_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [LIMB_W-1:0] res_sum,
  output logic              res_last,
  output logic              res_cout,
  output logic              res_of,
  output logic              busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_sub;

  logic [LIMB_W-1:0]  w_sum;
  logic               w_cout;
  logic               w_of;
  logic               w_op_fire;
  logic               w_is_last;

  assign w_op_fire = op_valid && op_ready;
  assign w_is_last = (r_cnt == CNT_W'(WORDS - 1));

  adder_sequencer_rca u_rca (
    .i_a   (op_a),
    .i_b   (r_sub ? ~op_b : op_b),
    .i_c   (r_carry),
    .o_sum (w_sum),
    .o_c   (w_cout),
    .o_of  (w_of)
  );

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    op_ready     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        // Single output slot: a new limb may enter as the previous one drains.
        op_ready = !res_valid || res_ready;
        if (w_op_fire && w_is_last) w_state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (res_valid && res_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_sub     <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_last  <= 1'b0;
      res_cout  <= 1'b0;
      res_of    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_sub   <= cmd_sub;
            r_carry <= cmd_sub ? 1'b1 : cmd_cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (w_op_fire) begin
            res_sum   <= w_sum;
            res_valid <= 1'b1;
            res_last  <= w_is_last;
            res_cout  <= w_is_last & w_cout;
            res_of    <= w_is_last & w_of;
            r_carry   <= w_cout;
            if (!w_is_last) r_cnt <= r_cnt + CNT_W'(1);
          end else if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench: constant vector table, randomized operations against a
// wide-integer reference model, backpressure and mid-operation reset sequences.
module tb_adder_sequencer;

  localparam int WORDS = 4;
  localparam int TW    = 32 * WORDS;
  localparam int LIM   = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_sub, cmd_cin;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [31:0] res_sum;
  logic        res_last, res_cout, res_of, busy;

  int n_cmp = 0;
  int n_bad = 0;

  adder_sequencer #(.WORDS(WORDS), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub), .cmd_cin(cmd_cin),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_last(res_last), .res_cout(res_cout), .res_of(res_of), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sub;
    logic          cin;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [TW-1:0] exp_sum;
    logic          exp_cout;
    logic          exp_of;
  } vec_t;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-width integer arithmetic and the two's-complement sign rules.
  function automatic void model(input logic sub, input logic cin, input logic [TW-1:0] a,
                                input logic [TW-1:0] b, output logic [TW-1:0] s,
                                output logic co, output logic of);
    logic [TW:0] full;
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      of = (a[TW-1] != b[TW-1]) && (s[TW-1] != a[TW-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
      s    = full[TW-1:0];
      co   = full[TW];
      of   = (a[TW-1] == b[TW-1]) && (s[TW-1] != a[TW-1]);
    end
  endfunction

  // mode 0: steady flow; 1: random gaps and backpressure; 2: 3-cycle stall on first result.
  task automatic run_op(input string tag, input logic sub, input logic cin,
                        input logic [TW-1:0] a, input logic [TW-1:0] b, input int mode,
                        output logic [TW-1:0] r, output logic co, output logic of);
    int sent = 0, got = 0, cyc = 0;
    bit held = 0;
    logic [TW-1:0] ms; logic mco, mof;
    model(sub, cin, a, b, ms, mco, mof);
    r = '0; co = 1'b0; of = 1'b0;
    @(negedge clk);
    chk({tag, "_cmd_ready"}, TW'(cmd_ready), TW'(1));
    cmd_valid = 1'b1; cmd_sub = sub; cmd_cin = cin;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_sub = 1'b0; cmd_cin = 1'b0;
    while (got < WORDS && cyc < LIM) begin
      if (mode == 2 && !held && res_valid) begin
        for (int k = 0; k < 3; k++) begin
          res_ready = 1'b0;
          op_valid  = (sent < WORDS);
          op_a = a[sent*32 +: 32]; op_b = b[sent*32 +: 32];
          #1;
          chk({tag, "_bp_op_ready"}, TW'(op_ready), TW'(0));
          chk({tag, "_bp_hold_sum"}, TW'(res_sum), TW'(ms[31:0]));
          @(negedge clk);
          cyc++;
        end
        held = 1;
      end
      op_valid  = (sent < WORDS) && (mode != 1 || $urandom_range(3) != 0);
      op_a      = (sent < WORDS) ? a[sent*32 +: 32] : $urandom;
      op_b      = (sent < WORDS) ? b[sent*32 +: 32] : $urandom;
      res_ready = (mode != 1) || ($urandom_range(2) != 0);
      #1;
      if (res_valid && res_ready) begin
        r[got*32 +: 32] = res_sum;
        chk({tag, "_last"}, TW'(res_last), TW'(got == WORDS - 1));
        if (got == WORDS - 1) begin
          co = res_cout; of = res_of;
        end else begin
          chk({tag, "_flags_mid"}, TW'({res_cout, res_of}), TW'(0));
        end
        got++;
      end
      if (op_valid && op_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0; res_ready = 1'b1;
    chk({tag, "_timeout"}, TW'(cyc >= LIM), TW'(0));
    if (mode == 0) chk({tag, "_cycles"}, TW'(cyc), TW'(WORDS + 1));
    chk({tag, "_idle_after"}, TW'({cmd_ready, busy}), TW'(2'b10));
    chk({tag, "_model_sum"}, r, ms);
    chk({tag, "_model_flags"}, TW'({co, of}), TW'({mco, mof}));
    $display("op %s sub=%0d cin=%0d a=%h b=%h sum=%h cout=%0d of=%0d", tag, sub, cin, a, b, r, co, of);
  endtask

  vec_t tbl[6];

  initial begin
    logic [TW-1:0] r, ra, rb;
    logic co, of, rs, rc;
    rst = 1'b1; cmd_valid = 0; cmd_sub = 0; cmd_cin = 0;
    op_valid = 0; op_a = 0; op_b = 0; res_ready = 1;

    tbl[0] = '{0, 0, TW'(32'hFFFFFFFF), TW'(1), TW'(64'h1_0000_0000), 0, 0};
    tbl[1] = '{0, 1, {TW{1'b1}}, {TW{1'b1}}, {TW{1'b1}}, 1, 0};
    tbl[2] = '{1, 0, TW'(0), TW'(1), {TW{1'b1}}, 0, 0};
    tbl[3] = '{0, 0, {32'h7FFFFFFF, 96'h0}, {32'h00000001, 96'h0}, {32'h80000000, 96'h0}, 0, 1};
    tbl[4] = '{1, 1, {32'h80000000, 96'h0}, TW'(1), {32'h7FFFFFFF, {96{1'b1}}}, 1, 1};
    tbl[5] = '{1, 0, TW'(32'h1234), TW'(32'h1234), TW'(0), 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_outputs", TW'({res_valid, res_last, res_cout, res_of, op_ready, busy}), TW'(0));
    chk("rst_sum", TW'(res_sum), TW'(0));
    chk("rst_cmd_ready", TW'(cmd_ready), TW'(1));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b, 0, r, co, of);
      chk($sformatf("tbl%0d_sum", i), r, tbl[i].exp_sum);
      chk($sformatf("tbl%0d_cout", i), TW'(co), TW'(tbl[i].exp_cout));
      chk($sformatf("tbl%0d_of", i), TW'(of), TW'(tbl[i].exp_of));
    end

    run_op("bp", 0, 0, {4{32'h89ABCDEF}}, {4{32'h76543211}}, 2, r, co, of);

    // Leave carry_q=1 after two limbs, then reset mid-operation.
    @(negedge clk);
    cmd_valid = 1; cmd_sub = 0; cmd_cin = 0;
    @(negedge clk);
    cmd_valid = 0; res_ready = 1; op_valid = 1; op_a = 32'hFFFFFFFF; op_b = 32'h1;
    @(negedge clk);
    op_a = 32'hFFFFFFFF; op_b = 32'h0;
    @(negedge clk);
    op_valid = 0;
    #1;
    chk("mid_pre_valid", TW'({res_valid, busy}), TW'(2'b11));
    rst = 1'b1;
    #1;
    chk("mid_rst_state", TW'({res_valid, cmd_ready, busy}), TW'(3'b010));
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 0, 0, TW'(1), TW'(1), 0, r, co, of);
    chk("post_rst_limb0", TW'(r[31:0]), TW'(32'h2));

    for (int t = 0; t < 16; t++) begin
      for (int w = 0; w < WORDS; w++) begin
        case ($urandom_range(4))
          0: begin ra[w*32 +: 32] = 32'hFFFFFFFF; rb[w*32 +: 32] = $urandom; end
          1: begin ra[w*32 +: 32] = 32'h7FFFFFFF; rb[w*32 +: 32] = 32'h80000000; end
          default: begin ra[w*32 +: 32] = $urandom; rb[w*32 +: 32] = $urandom; end
        endcase
      end
      rs = 1'($urandom_range(1)); rc = 1'($urandom_range(1));
      run_op($sformatf("rnd%0d", t), rs, rc, ra, rb, 1, r, co, of);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
